ads1115_i2c_master: RTL and testbench



---
 rtl/ads1115_i2c_master.sv | 230 +++++++++++++++++++++++
 tb/tb_ads1115_i2c_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1115_i2c_master.sv
// I2C master that configures a TI ADS1115 and reads conversion results in a loop while start is high.
// Define ACK_CHECK_EN to abandon a frame (and set a sticky ack_error) when the slave NACKs.
module ads1115_i2c_master #(
  parameter logic [6:0]  SLAVE_ADDR       = 7'h48,
  parameter logic [15:0] CONFIG_WORD      = 16'hC383,
  parameter int          QTR_CYCLES       = 2,
  parameter int          CONV_WAIT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        SCL,
  inout  wire         SDA,
  output logic [3:0]  state_checkw,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        ack_error
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_START      = 4'd1,
    S_TX_BYTE    = 4'd2,
    S_SLAVE_ACK  = 4'd3,
    S_BUS_FREE   = 4'd4,
    S_CONV_WAIT  = 4'd5,
    S_RX_BYTE    = 4'd6,
    S_MASTER_ACK = 4'd7,
    S_STOP       = 4'd8
  } state_t;

  localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR_CYCLES - 1);
  localparam int WW = (CONV_WAIT_CYCLES > 1) ? $clog2(CONV_WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(CONV_WAIT_CYCLES - 1);

  localparam logic [1:0] TR_CFG  = 2'd0;
  localparam logic [1:0] TR_PTR  = 2'd1;
  localparam logic [1:0] TR_READ = 2'd2;

  state_t          state, state_d;
  logic [QW-1:0]   qcnt;
  logic [1:0]      qtr;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [1:0]      trans;
  logic [15:0]     rx_shift;
  logic            slot_end;
  logic            last_tx;
  logic            ack_fail;
  logic            abort;
  logic            scl_o;
  logic            sda_o;
  logic            sda_oe;
  logic            sda_in;
  logic [7:0]      tx_byte;

  // Byte to transmit for the current transaction and byte position.
  function automatic logic [7:0] tx_byte_sel(input logic [1:0] tr, input logic [1:0] idx);
    logic [7:0] b;
    if (idx == 2'd0) begin
      b = {SLAVE_ADDR, (tr == TR_READ)};
    end else if (tr == TR_CFG) begin
      case (idx)
        2'd1:    b = 8'h01;
        2'd2:    b = CONFIG_WORD[15:8];
        default: b = CONFIG_WORD[7:0];
      endcase
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  assign SDA          = sda_oe ? sda_o : 1'bz;
  assign sda_in       = SDA;
  assign SCL          = scl_o;
  assign state_checkw = state;
  assign slot_end     = (qtr == 2'd3) && (qcnt == QTR_LAST);
  assign tx_byte      = tx_byte_sel(trans, byte_cnt);
  assign last_tx      = ((trans == TR_CFG) && (byte_cnt == 2'd3)) ||
                        ((trans == TR_PTR) && (byte_cnt == 2'd1));

`ifdef ACK_CHECK_EN
  assign ack_fail = sda_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_error <= 1'b0;
      abort     <= 1'b0;
    end else begin
      if (state == S_SLAVE_ACK && slot_end && sda_in) begin
        ack_error <= 1'b1;
        abort     <= 1'b1;
      end else if (state == S_IDLE) begin
        abort <= 1'b0;
      end
    end
  end
`else
  assign ack_fail  = 1'b0;
  assign abort     = 1'b0;
  assign ack_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Bit-slot timing restarts on every state change, which in slot states coincides with a slot end.
  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt     <= '0;
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      wait_cnt <= '0;
      trans    <= TR_CFG;
    end else begin
      if (state_d != state) begin
        qcnt     <= '0;
        qtr      <= 2'd0;
        bit_cnt  <= 3'd0;
        wait_cnt <= '0;
      end else begin
        if (qcnt == QTR_LAST) begin
          qcnt <= '0;
          qtr  <= qtr + 2'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
        if (slot_end) bit_cnt <= bit_cnt + 3'd1;
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == S_START) begin
        byte_cnt <= 2'd0;
      end else if ((state == S_SLAVE_ACK || state == S_MASTER_ACK) && slot_end) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      case (state)
        S_IDLE:      trans <= TR_CFG;
        S_CONV_WAIT: trans <= TR_PTR;
        S_BUS_FREE:  trans <= TR_READ;
        default:     trans <= trans;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RX_BYTE && slot_end) rx_shift <= {rx_shift[14:0], sda_in};
  end

  // Result publishes at the end of the read transaction's STOP slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == S_STOP && slot_end && trans == TR_READ && !abort) begin
        data_out   <= rx_shift;
        data_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    scl_o   = 1'b1;
    sda_o   = 1'b1;
    sda_oe  = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        sda_o = ~qtr[1];
        if (slot_end) state_d = S_TX_BYTE;
      end
      S_TX_BYTE: begin
        scl_o = qtr[1];
        sda_o = tx_byte[3'd7 - bit_cnt];
        if (slot_end && bit_cnt == 3'd7) state_d = S_SLAVE_ACK;
      end
      S_SLAVE_ACK: begin
        scl_o  = qtr[1];
        sda_oe = 1'b0;
        if (slot_end) begin
          if (ack_fail)              state_d = S_STOP;
          else if (trans == TR_READ) state_d = S_RX_BYTE;
          else if (last_tx)          state_d = S_STOP;
          else                       state_d = S_TX_BYTE;
        end
      end
      S_RX_BYTE: begin
        scl_o  = qtr[1];
        sda_oe = 1'b0;
        if (slot_end && bit_cnt == 3'd7) state_d = S_MASTER_ACK;
      end
      S_MASTER_ACK: begin
        scl_o = qtr[1];
        sda_o = (byte_cnt == 2'd2);
        if (slot_end) state_d = (byte_cnt == 2'd2) ? S_STOP : S_RX_BYTE;
      end
      S_STOP: begin
        scl_o = qtr[1];
        sda_o = (qtr == 2'd3);
        if (slot_end) begin
          if (abort)                state_d = S_IDLE;
          else if (trans == TR_CFG) state_d = S_CONV_WAIT;
          else if (trans == TR_PTR) state_d = S_BUS_FREE;
          else                      state_d = S_IDLE;
        end
      end
      S_CONV_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_d = S_START;
      end
      S_BUS_FREE: begin
        if (slot_end) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ads1115_i2c_master.sv
// Self-checking bench for ads1115_i2c_master: ADS1115 slave responder, bus monitor and
// a frame-level reference of the expected byte stream and read results.
module tb_ads1115_i2c_master;

  localparam logic [6:0]  ADDR = 7'h48;
  localparam logic [15:0] CFG  = 16'hC383;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        SCL;
  wire         SDA;
  logic [3:0]  state_checkw;
  logic [15:0] data_out;
  logic        data_valid;
  logic        ack_error;

  int n_checks = 0;
  int n_errors = 0;

  // Slave responder state
  logic        ack_bit = 1'b0;
  logic [15:0] slv_word = 16'h0000;
  logic [15:0] slv_q[$];
  int          rx_cnt = 0;
  logic        slv_oe;
  logic        slv_bit;

  // Monitor state
  logic [7:0]  tx_q[$];
  logic        mack_q[$];
  logic [15:0] dv_q[$];
  logic [7:0]  mon_byte = 8'h00;
  int          mon_bits = 0;
  int          stop_cnt = 0;
  int          startc = 0;
  int          stopc = 0;
  int          dv_long = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        prev_dv = 1'b0;
  logic [3:0]  prev_state = 4'd0;

  logic [7:0]  exp_frame [7];
  logic [15:0] words [6];

  ads1115_i2c_master #(
    .SLAVE_ADDR(ADDR),
    .CONFIG_WORD(CFG),
    .QTR_CYCLES(2),
    .CONV_WAIT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .SCL(SCL),
    .SDA(SDA),
    .state_checkw(state_checkw),
    .data_out(data_out),
    .data_valid(data_valid),
    .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  assign slv_oe  = (state_checkw == 4'd3) || (state_checkw == 4'd6);
  assign slv_bit = (state_checkw == 4'd3) ? ack_bit : slv_word[4'(15 - rx_cnt)];
  assign SDA     = slv_oe ? slv_bit : 1'bz;

  // Slave shifts its next read bit out after each SCL fall that ends a read-bit slot.
  initial begin
    forever begin
      @(posedge SCL);
      if (state_checkw == 4'd6) begin
        @(negedge SCL);
        rx_cnt = rx_cnt + 1;
        if (rx_cnt == 16) begin
          rx_cnt = 0;
          if (slv_q.size() > 0) slv_word = slv_q.pop_front();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (state_checkw == 4'd1) begin
      mon_bits <= 0;
    end else if (!prev_scl && SCL && state_checkw == 4'd2) begin
      if (mon_bits == 7) begin
        tx_q.push_back({mon_byte[6:0], SDA});
        mon_bits <= 0;
      end else begin
        mon_bits <= mon_bits + 1;
      end
      mon_byte <= {mon_byte[6:0], SDA};
    end
    if (!prev_scl && SCL && state_checkw == 4'd7) mack_q.push_back(SDA);
    if (state_checkw == 4'd8 && prev_state != 4'd8) stop_cnt <= stop_cnt + 1;
    if (state_checkw == 4'd1 && prev_state == 4'd1 && prev_scl && SCL && prev_sda && !SDA)
      startc <= startc + 1;
    if (state_checkw == 4'd8 && prev_state == 4'd8 && prev_scl && SCL && !prev_sda && SDA)
      stopc <= stopc + 1;
    if (data_valid) begin
      dv_q.push_back(data_out);
      if (prev_dv) dv_long <= dv_long + 1;
    end
    prev_scl   <= SCL;
    prev_sda   <= SDA;
    prev_dv    <= data_valid;
    prev_state <= state_checkw;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int i = 0;
    while (state_checkw !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(state_checkw), 32'(s));
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int i = 0;
    while (state_checkw === 4'd0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(state_checkw != 4'd0), 32'd1);
  endtask

  task automatic wait_dv(input int n, input int budget, input string tag);
    int i = 0;
    while (dv_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(dv_q.size()), 32'(n));
  endtask

  task automatic check_frames(input int first_frame, input int nframes);
    for (int f = first_frame; f < first_frame + nframes; f++) begin
      for (int b = 0; b < 7; b++)
        chk($sformatf("txbyte_f%0d_b%0d", f, b), 32'(tx_q[f*7+b]), 32'(exp_frame[b]));
      chk($sformatf("mack0_f%0d", f), 32'(mack_q[f*2]), 32'd0);
      chk($sformatf("mack1_f%0d", f), 32'(mack_q[f*2+1]), 32'd1);
      chk($sformatf("rdata_f%0d", f), 32'(dv_q[f]), 32'(words[f]));
    end
  endtask

  initial begin
    exp_frame[0] = {ADDR, 1'b0};
    exp_frame[1] = 8'h01;
    exp_frame[2] = CFG[15:8];
    exp_frame[3] = CFG[7:0];
    exp_frame[4] = {ADDR, 1'b0};
    exp_frame[5] = 8'h00;
    exp_frame[6] = {ADDR, 1'b1};
    words[0] = 16'h9CE0;
    words[1] = 16'h9CE3;
    words[2] = 16'h9CC0;
    words[3] = 16'h1CE3;
    words[4] = 16'($urandom);
    words[5] = 16'($urandom);

    // Reset held for 10 clocks
    repeat (10) @(negedge clk);
    chk("rst_state", 32'(state_checkw), 32'd0);
    chk("rst_scl", 32'(SCL), 32'd1);
    chk("rst_sda", 32'(SDA), 32'd1);
    chk("rst_data", 32'(data_out), 32'h0000);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_ackerr", 32'(ack_error), 32'd0);

    // Four back-to-back frames, start dropped during the fourth frame's pointer write
    slv_word = words[0];
    for (int i = 1; i < 4; i++) slv_q.push_back(words[i]);
    ack_bit = 1'b0;
    reset = 1'b0;
    start = 1'b1;
    wait_state(4'd1, 5, "enter_start");
    chk("start_q0_scl", 32'(SCL), 32'd1);
    chk("start_q0_sda", 32'(SDA), 32'd1);
    wait_state(4'd2, 20, "enter_tx");
    chk("start_cond", 32'(startc), 32'd1);
    wait_dv(3, 4000, "dv_three");
    wait_busy(10, "frame4_begin");
    wait_state(4'd5, 600, "frame4_convwait");
    wait_state(4'd1, 100, "frame4_t2_start");
    start = 1'b0;
    wait_dv(4, 1500, "dv_four");
    repeat (100) @(negedge clk);
    chk("idle_state", 32'(state_checkw), 32'd0);
    chk("idle_scl", 32'(SCL), 32'd1);
    chk("idle_sda", 32'(SDA), 32'd1);
    chk("stop_entries", 32'(stop_cnt), 32'd12);
    chk("start_conds", 32'(startc), 32'd12);
    chk("stop_conds", 32'(stopc), 32'd12);
    chk("dv_pulse_len", 32'(dv_long), 32'd0);
    chk("tx_count", 32'(tx_q.size()), 32'd28);
    chk("mack_count", 32'(mack_q.size()), 32'd8);
    chk("dv_count", 32'(dv_q.size()), 32'd4);
    chk("data_last", 32'(data_out), 32'(words[3]));
    check_frames(0, 4);

    // Two frames of random read data; without ack checking the slave NACKs every byte
`ifndef ACK_CHECK_EN
    ack_bit = 1'b1;
`endif
    slv_word = words[4];
    slv_q.push_back(words[5]);
    start = 1'b1;
    wait_dv(5, 1500, "dv_five");
    wait_busy(10, "frame6_begin");
    start = 1'b0;
    wait_dv(6, 1500, "dv_six");
    repeat (30) @(negedge clk);
    chk("rand_stops", 32'(stop_cnt), 32'd18);
    chk("rand_tx_count", 32'(tx_q.size()), 32'd42);
    chk("rand_ackerr", 32'(ack_error), 32'd0);
    chk("rand_data_last", 32'(data_out), 32'(words[5]));
    chk("rand_dv_len", 32'(dv_long), 32'd0);
    check_frames(4, 2);

`ifdef ACK_CHECK_EN
    // Slave NACKs the address byte: frame abandoned with an immediate STOP
    ack_bit = 1'b1;
    start = 1'b1;
    begin
      int i = 0;
      while (ack_error !== 1'b1 && i < 300) begin
        @(negedge clk);
        i++;
      end
    end
    start = 1'b0;
    chk("nack_ackerr", 32'(ack_error), 32'd1);
    chk("nack_to_stop", 32'(state_checkw), 32'd8);
    repeat (60) @(negedge clk);
    chk("nack_idle", 32'(state_checkw), 32'd0);
    chk("nack_stops", 32'(stop_cnt), 32'd19);
    chk("nack_no_dv", 32'(dv_q.size()), 32'd6);
    chk("nack_tx_count", 32'(tx_q.size()), 32'd43);
    chk("nack_data_hold", 32'(data_out), 32'(words[5]));
    ack_bit = 1'b0;
`endif

    // Reset in the middle of a byte aborts at once
    start = 1'b1;
    wait_state(4'd2, 20, "mid_tx");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(state_checkw), 32'd0);
    chk("midrst_scl", 32'(SCL), 32'd1);
    chk("midrst_sda", 32'(SDA), 32'd1);
    chk("midrst_data", 32'(data_out), 32'h0000);
    chk("midrst_ackerr", 32'(ack_error), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'(state_checkw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
